// File: rtl/vpu_pipe.sv
// rtl/vpu_pipe.sv - four-stage bias / leaky-ReLU / loss / leaky-ReLU-derivative vector pipeline
module vpu_pipe #(
    parameter int LANES  = 2,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              cfg_pathway,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_mask,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*DATA_W-1:0] bias_in,
    input  logic [LANES*DATA_W-1:0] y_in,
    input  logic [LANES*DATA_W-1:0] h_in,
    input  logic [DATA_W-1:0]       leak_factor,
    input  logic [DATA_W-1:0]       inv_batch_x2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_mask,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    busy,
    output logic                    sat_sticky,
    input  logic                    sat_clr
);
    localparam int VW = LANES * DATA_W;
    localparam int XW = 2 * DATA_W + 2;
    typedef logic signed [XW-1:0] wide_t;
    localparam wide_t MAXV = wide_t'({1'b0, {(DATA_W-1){1'b1}}});
    localparam wide_t MINV = ~MAXV;

    // Result packs {overflow, value}.
    function automatic logic [DATA_W:0] sat_w(input wide_t v);
        if (v > MAXV)      sat_w = {1'b1, MAXV[DATA_W-1:0]};
        else if (v < MINV) sat_w = {1'b1, MINV[DATA_W-1:0]};
        else               sat_w = {1'b0, v[DATA_W-1:0]};
    endfunction

    function automatic logic signed [DATA_W:0] ext(input logic [DATA_W-1:0] v);
        ext = {v[DATA_W-1], v};
    endfunction

    function automatic logic [DATA_W:0] mul_sh(input logic signed [DATA_W:0] a,
                                               input logic signed [DATA_W-1:0] b);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        mul_sh = sat_w(p >>> FRAC);
    endfunction

    logic              s1_valid, s2_valid, s3_valid, s4_valid;
    logic [LANES-1:0]  s1_mask, s2_mask, s3_mask, s4_mask;
    logic [2:0]        s1_pw;
    logic [1:0]        s2_pw, s3_pw;
    logic [VW-1:0]     s1_data, s2_data, s3_data, s4_data;
    logic [VW-1:0]     s1_y, s2_y, s1_hext, s2_hext, s3_hext, s3_hfwd;
    logic [VW-1:0]     n1_data, n2_data, n3_data, n4_data;
    logic [LANES-1:0]  o1, o2, o3, o4;
    logic [DATA_W:0]   r1, r2, r3, r4;
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0] hsel;
    logic              advance, sat_hit;

    assign advance   = !s4_valid || out_ready;
    assign in_ready  = advance && !rst;
    assign busy      = s1_valid || s2_valid || s3_valid || s4_valid;
    assign out_valid = s4_valid;
    assign out_mask  = s4_mask;
    assign out_data  = s4_data;

    always_comb begin
        n1_data = in_data;
        n2_data = s1_data;
        n3_data = s2_data;
        n4_data = s3_data;
        o1 = '0; o2 = '0; o3 = '0; o4 = '0;
        r1 = '0; r2 = '0; r3 = '0; r4 = '0;
        diff = '0;
        hsel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cfg_pathway[3]) begin
                r1 = sat_w(wide_t'(ext(in_data[i*DATA_W +: DATA_W]) + ext(bias_in[i*DATA_W +: DATA_W])));
                n1_data[i*DATA_W +: DATA_W] = r1[DATA_W-1:0];
                o1[i] = r1[DATA_W];
            end
            if (s1_pw[2] && s1_data[i*DATA_W + DATA_W - 1]) begin
                r2 = mul_sh(ext(s1_data[i*DATA_W +: DATA_W]), leak_factor);
                n2_data[i*DATA_W +: DATA_W] = r2[DATA_W-1:0];
                o2[i] = r2[DATA_W];
            end
            if (s2_pw[1]) begin
                diff = ext(s2_data[i*DATA_W +: DATA_W]) - ext(s2_y[i*DATA_W +: DATA_W]);
                r3 = mul_sh(diff, inv_batch_x2);
                n3_data[i*DATA_W +: DATA_W] = r3[DATA_W-1:0];
                o3[i] = r3[DATA_W];
            end
            // Transition beats use their own forwarded H; others use the external H.
            hsel = s3_pw[1] ? s3_hfwd[i*DATA_W +: DATA_W] : s3_hext[i*DATA_W +: DATA_W];
            if (s3_pw[0] && (hsel[DATA_W-1] || hsel == '0)) begin
                r4 = mul_sh(ext(s3_data[i*DATA_W +: DATA_W]), leak_factor);
                n4_data[i*DATA_W +: DATA_W] = r4[DATA_W-1:0];
                o4[i] = r4[DATA_W];
            end
        end
        sat_hit = (in_valid && |(o1 & in_mask)) || (s1_valid && |(o2 & s1_mask)) ||
                  (s2_valid && |(o3 & s2_mask)) || (s3_valid && |(o4 & s3_mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0; s4_valid <= 1'b0;
            s1_mask <= '0; s2_mask <= '0; s3_mask <= '0; s4_mask <= '0;
            s1_pw <= '0; s2_pw <= '0; s3_pw <= '0;
            s1_data <= '0; s2_data <= '0; s3_data <= '0; s4_data <= '0;
            s1_y <= '0; s2_y <= '0;
            s1_hext <= '0; s2_hext <= '0; s3_hext <= '0; s3_hfwd <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (advance) begin
                s1_valid <= in_valid;  s1_mask <= in_mask;  s1_pw <= cfg_pathway[2:0];
                s1_data  <= n1_data;   s1_y    <= y_in;     s1_hext <= h_in;
                s2_valid <= s1_valid;  s2_mask <= s1_mask;  s2_pw <= s1_pw[1:0];
                s2_data  <= n2_data;   s2_y    <= s1_y;     s2_hext <= s1_hext;
                s3_valid <= s2_valid;  s3_mask <= s2_mask;  s3_pw <= s2_pw;
                s3_data  <= n3_data;   s3_hext <= s2_hext;  s3_hfwd <= s2_data;
                s4_valid <= s3_valid;  s4_mask <= s3_mask;  s4_data <= n4_data;
            end
            if (advance && sat_hit) sat_sticky <= 1'b1;
            else if (sat_clr)       sat_sticky <= 1'b0;
        end
    end
endmodule
